// File: rtl/muldiv_sched.sv
// Execute-stage scheduler for multi-cycle MULT/MULTU/DIV/DIVU and the HI/LO register pair.
// State | meaning: IDLE accept ops, MTHI/MTLO | MUL multiply countdown | DIV restoring divide | DONE commit pulse
module muldiv_sched #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

  stateT              state, nextState;
  logic [CNT_W-1:0]   counter;
  logic [WIDTH-1:0]   opA, opB, remReg;
  logic               mulSigned, negQuot, negRem, divZero;

  logic               accept, isMul, isDiv, signedDiv, aNeg, bNeg, counterZero;
  logic [WIDTH-1:0]   absA, absB;
  logic [2*WIDTH-1:0] extA, extB, product;
  logic [WIDTH:0]     shifted, diff;
  logic               qBit;
  logic [WIDTH-1:0]   nextQ, nextRem, quotFix, remFix, rawDividend;

  assign accept      = (state == IDLE) && start && !flush;
  assign isMul       = (op == 3'd1) || (op == 3'd2);
  assign isDiv       = (op == 3'd3) || (op == 3'd4);
  assign signedDiv   = (op == 3'd3);
  assign aNeg        = signedDiv && src_a[WIDTH-1];
  assign bNeg        = signedDiv && src_b[WIDTH-1];
  assign absA        = aNeg ? -src_a : src_a;
  assign absB        = bNeg ? -src_b : src_b;
  assign counterZero = (counter == '0);

  // Sign-extending both operands to 2*WIDTH lets one multiplier serve MULT and MULTU.
  assign extA    = {{WIDTH{mulSigned & opA[WIDTH-1]}}, opA};
  assign extB    = {{WIDTH{mulSigned & opB[WIDTH-1]}}, opB};
  assign product = extA * extB;

  // One restoring step: opA shifts the dividend out MSB-first and collects quotient bits.
  assign shifted     = {remReg, opA[WIDTH-1]};
  assign diff        = shifted - {1'b0, opB};
  assign qBit        = !diff[WIDTH];
  assign nextRem     = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign nextQ       = {opA[WIDTH-2:0], qBit};
  assign quotFix     = negQuot ? -nextQ : nextQ;
  assign remFix      = negRem ? -nextRem : nextRem;
  assign rawDividend = negRem ? -opA : opA;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    stall_req = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        stall_req = start && (isMul || isDiv) && !flush;
        if (accept && isMul)      nextState = MUL;
        else if (accept && isDiv) nextState = DIV;
      end
      MUL, DIV: begin
        stall_req = 1'b1;
        if (flush)            nextState = IDLE;
        else if (counterZero) nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter   <= '0;
      opA       <= '0;
      opB       <= '0;
      remReg    <= '0;
      mulSigned <= 1'b0;
      negQuot   <= 1'b0;
      negRem    <= 1'b0;
      divZero   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (isMul) begin
              opA       <= src_a;
              opB       <= src_b;
              mulSigned <= (op == 3'd1);
              counter   <= CNT_W'(MUL_LAT - 2);
            end else if (isDiv) begin
              opA     <= absA;
              opB     <= absB;
              remReg  <= '0;
              negQuot <= aNeg ^ bNeg;
              negRem  <= aNeg;
              divZero <= (src_b == '0);
              counter <= CNT_W'(WIDTH - 1);
            end else if (op == 3'd5) begin
              hi <= src_a;
            end else if (op == 3'd6) begin
              lo <= src_a;
            end
          end
        end
        MUL: begin
          if (!flush) begin
            if (counterZero) {hi, lo} <= product;
            else             counter  <= counter - 1'b1;
          end
        end
        DIV: begin
          if (!flush) begin
            // A zero divisor idles the datapath so the dividend survives for HI.
            if (!divZero) begin
              opA    <= nextQ;
              remReg <= nextRem;
            end
            if (counterZero) begin
              if (divZero) begin
                lo <= '1;
                hi <= rawDividend;
              end else begin
                lo <= quotFix;
                hi <= remFix;
              end
            end else begin
              counter <= counter - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
